pipe_addsub: RTL
================

PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, giving the pipeline depth and the number of carry chunks; chunk width W = N/STAGES.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operand beat valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-008 The block SHALL have port a, input, N bits: operand A.
REQ-009 The block SHALL have port b, input, N bits: operand B.
REQ-010 The block SHALL have port sub, input, 1 bit: 0 computes A+B, 1 computes A-B.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result beat valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 The block SHALL have port sum, output, N bits: result.
REQ-014 The block SHALL have port cout, output, 1 bit: carry out of bit N-1.
REQ-015 The block SHALL have port ovf, output, 1 bit: signed two's-complement overflow.
REQ-016 The block SHALL have port zero, output, 1 bit: sum == 0.
REQ-017 The block SHALL have port neg, output, 1 bit: sum[N-1].

Function
REQ-018 The block SHALL fail elaboration when N % STAGES != 0 or STAGES < 1.
REQ-019 Effective B SHALL be b XOR {N{sub}}, and the carry into bit 0 SHALL be sub.
REQ-020 Stage k (0..STAGES-1) SHALL add chunk k (bits k*W+W-1 .. k*W) using the carry registered by stage k-1; stage 0 SHALL use sub.
REQ-021 Operand chunks consumed by later stages SHALL be delayed through skew registers, and completed low chunks SHALL be delayed through deskew registers so that all N result bits of one beat emerge together.
REQ-022 Latency SHALL be exactly STAGES cycles from an accepted input (in_valid && in_ready at edge t) to out_valid high after edge t+STAGES-1, with no stall in between.
REQ-023 Throughput SHALL be one beat per cycle with no bubbles while out_ready is held high.
REQ-024 A stall, defined as stall = out_valid && !out_ready, SHALL freeze every pipeline register, including valid bits and carries.
REQ-025 in_ready SHALL equal !stall, combinationally.
REQ-026 While stalled, sum, cout, ovf, zero and neg SHALL hold their values stable.
REQ-027 Bubbles (in_valid = 0 on an accepted cycle) SHALL propagate as invalid entries, and their data SHALL be don't-care.
REQ-028 cout SHALL be the carry out of bit N-1; for sub = 1, cout = 1 means no borrow (A >= B unsigned).
REQ-029 ovf SHALL be 1 iff a[N-1] == effB[N-1] and sum[N-1] != a[N-1].
REQ-030 ovf, zero and neg SHALL be computed from the same beat as sum and be aligned with it.
REQ-031 For STAGES = 1, the block SHALL degenerate to a single registered N-bit adder with latency 1.
REQ-032 Values sampled on a and b when in_valid is low SHALL have no effect on any valid result.

Reset
REQ-033 Assertion of rst_n low SHALL immediately clear all valid bits, carries, sum, cout, ovf, zero and neg to 0, regardless of the clock.
REQ-034 After reset, in_ready SHALL read 1 and out_valid SHALL read 0.
REQ-035 Beats in flight when reset asserts SHALL be discarded and never appear at the output.
REQ-036 The first edge after rst_n deasserts SHALL be able to accept a beat.

Verification
REQ-037 The bench SHALL cover N=32, STAGES=4, single beat: a=0x0000_00FF, b=0x0000_0001, sub=0 -> after 4 cycles, sum=0x0000_0100, cout=0, ovf=0, zero=0, neg=0.
REQ-038 The bench SHALL cover cross-chunk carry: a=0xFFFF_FFFF, b=0x0000_0001, sub=0 -> sum=0, cout=1, zero=1, ovf=0.
REQ-039 The bench SHALL cover overflow and subtract: a=0x7FFF_FFFF, b=1, sub=0 -> sum=0x8000_0000, ovf=1, neg=1; then a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0, neg=1.
REQ-040 The bench SHALL cover a streaming stall: 8 back-to-back beats with out_ready low for cycles 6-8 -> in_ready low during the stall, outputs held, all 8 results delivered in order, none lost or duplicated.
REQ-041 The bench SHALL cover reset mid-stream: 3 beats in flight, then rst_n pulsed low -> out_valid=0 immediately, and no stale beat is delivered after release.
REQ-042 The bench SHALL cover a STAGES=1 build and a STAGES=8 build against a random reference model over 10k beats with random in_valid and out_ready -> exact match on sum and all flags.

Source files
------------

// File: rtl/pipe_addsub.sv
// Pipelined N-bit adder/subtractor: the carry chain is split into STAGES chunks,
// one chunk per pipeline stage, with valid/ready flow control at both ends.
module pipe_addsub #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);

  localparam int W    = N / STAGES;
  localparam int LAST = STAGES - 1;

  if ((STAGES < 1) || (N % STAGES != 0)) begin : g_bad_cfg
    $error("pipe_addsub: N must be a multiple of STAGES and STAGES >= 1");
  end

  logic         stall;

  // Per-stage inputs: stage 0 reads the ports, stage k reads the registers of stage k-1
  logic [N-1:0] a_in  [STAGES];
  logic [N-1:0] b_in  [STAGES];
  logic [N-1:0] r_in  [STAGES];
  logic         c_in  [STAGES];
  logic         v_in  [STAGES];
  logic [W:0]   chunk [STAGES];

  logic         vld_d   [STAGES];
  logic         vld_q   [STAGES];
  logic         carry_d [STAGES];
  logic         carry_q [STAGES];
  logic [N-1:0] res_d   [STAGES];
  logic [N-1:0] res_q   [STAGES];
  logic [N-1:0] opa_d   [STAGES];
  logic [N-1:0] opa_q   [STAGES];
  logic [N-1:0] opb_d   [STAGES];
  logic [N-1:0] opb_q   [STAGES];

  logic         ovf_d,  ovf_q;
  logic         zero_d, zero_q;
  logic         neg_d,  neg_q;

  assign stall     = vld_q[LAST] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = vld_q[LAST];
  assign sum       = res_q[LAST];
  assign cout      = carry_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

  always_comb begin
    a_in[0] = a;
    b_in[0] = b ^ {N{sub}};
    r_in[0] = '0;
    c_in[0] = sub;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = opa_q[k-1];
      b_in[k] = opb_q[k-1];
      r_in[k] = res_q[k-1];
      c_in[k] = carry_q[k-1];
      v_in[k] = vld_q[k-1];
    end

    // Each stage resolves one chunk; operands ride along as skew, finished chunks as deskew
    for (int k = 0; k < STAGES; k++) begin
      chunk[k]   = {1'b0, a_in[k][k*W +: W]} + {1'b0, b_in[k][k*W +: W]}
                 + {{W{1'b0}}, c_in[k]};
      vld_d[k]   = v_in[k];
      carry_d[k] = chunk[k][W];
      opa_d[k]   = a_in[k];
      opb_d[k]   = b_in[k];
      res_d[k]   = r_in[k];
      res_d[k][k*W +: W] = chunk[k][W-1:0];
    end

    // Flags are registered with the final chunk so they stay aligned with sum
    ovf_d  = (a_in[LAST][N-1] == b_in[LAST][N-1]) && (res_d[LAST][N-1] != a_in[LAST][N-1]);
    zero_d = (res_d[LAST] == '0);
    neg_d  = res_d[LAST][N-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]   <= 1'b0;
        carry_q[k] <= 1'b0;
        res_q[k]   <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]   <= vld_d[k];
        carry_q[k] <= carry_d[k];
        res_q[k]   <= res_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  // Operand skew registers carry no reset; their contents only matter under a valid bit
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
      end
    end
  end

endmodule
